// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: buffers the two previous rows of a raster pixel stream and
// emits one packed 72-bit neighbourhood per pixel whose window lies fully inside the frame.
module line_window_gen #(
    parameter int unsigned IMG_WIDTH  = 512,
    parameter int unsigned IMG_HEIGHT = 512
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_frame_done
);

    localparam int unsigned ColW = $clog2(IMG_WIDTH);
    localparam int unsigned RowW = $clog2(IMG_HEIGHT);

    localparam logic [ColW-1:0] ColLast  = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0] RowLast  = RowW'(IMG_HEIGHT - 1);
    localparam logic [ColW-1:0] ColFirst = ColW'(2);
    localparam logic [RowW-1:0] RowFirst = RowW'(2);

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [71:0]     win_q, win_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    // Line A holds row y-1, line B holds row y-2; contents are never reset.
    logic [7:0] line_a_q [IMG_WIDTH];
    logic [7:0] line_b_q [IMG_WIDTH];

    logic [7:0] tap1, tap2;
    logic       col_last, row_last;

    assign tap1     = line_a_q[col_q];
    assign tap2     = line_b_q[col_q];
    assign col_last = (col_q == ColLast);
    assign row_last = (row_q == RowLast);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        if (i_pixel_data_valid) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Each row of the window shifts left by one byte; the new column enters at c = 2.
            for (int r = 0; r < 3; r++) begin
                win_d[24*r +: 8]     = win_q[24*r + 8 +: 8];
                win_d[24*r + 8 +: 8] = win_q[24*r + 16 +: 8];
            end
            win_d[23:16] = tap2;
            win_d[47:40] = tap1;
            win_d[71:64] = i_pixel_data;
            valid_d      = (row_q >= RowFirst) && (col_q >= ColFirst);
            done_d       = col_last && row_last;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_pixel_data_valid) begin
            line_b_q[col_q] <= tap1;
            line_a_q[col_q] <= i_pixel_data;
        end
    end

    assign o_pixel_data       = win_q;
    assign o_pixel_data_valid = valid_q;
    assign o_frame_done       = done_q;

endmodule

// File: doc/line_window_gen.md
# line_window_gen

Streaming 3x3 window generator that feeds the convolution stage. It accepts a raster-order 8-bit pixel stream, stores the two previous image rows in internal line buffers, and emits one 72-bit 3x3 neighbourhood per eligible input pixel. The output is in exactly the packed format the convolver consumes on its `i_pixel_data` / `i_pixel_data_valid` inputs. It is the producer end of that 72-bit window interface.

## Interface
- `IMG_WIDTH`, default 512: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, default 512: rows per frame; must be ≥ 3.
- `i_clk` input 1: single clock; all logic on its rising edge.
- `i_rstn` input 1: reset, asynchronous and active-low.
- `i_pixel_data` input 8: incoming pixel, raster order (row 0 col 0 first).
- `i_pixel_data_valid` input 1: pixel accepted on every rising edge where high; no backpressure.
- `o_pixel_data` output 72: packed 3x3 window.
- `o_pixel_data_valid` output 1: one-cycle qualifier per window.
- `o_frame_done` output 1: one-cycle pulse after the last pixel of a frame.

## Operation
- Column counter `col` runs 0..IMG_WIDTH-1. Row counter `row` runs 0..IMG_HEIGHT-1. Both advance only on accepted pixels.
  - `col` wraps to 0 and `row` increments at end of row.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1, both wrap to 0.
- Line buffer A (IMG_WIDTH x 8) holds row y-1. Line buffer B (IMG_WIDTH x 8) holds row y-2.
- On an accepted pixel p at (y, x):
  - tap1 = A[x], tap2 = B[x], both read before write.
  - Write B[x] ← tap1 and A[x] ← p.
- Column vector {top = tap2, mid = tap1, bot = p} shifts into a 3-column window register. The newest column enters at the right (c = 2); the oldest drops from the left (c = 0).
- Window packing: byte k = 3r + c occupies bits [8k+7 : 8k].
  - r = 0 is the top row (y-2) and r = 2 is the bottom row (y).
  - c = 0 is the left column (x-2) and c = 2 is the right column (x).
  - Byte 4 is the centre pixel (y-1, x-1). Byte 8 is the newest pixel p.
- A window is eligible iff the accepted pixel has row ≥ 2 and col ≥ 2. Windows straddling a row boundary or the top two rows are never emitted (no padding).
- Output count per frame is exactly (IMG_WIDTH-2)·(IMG_HEIGHT-2).
- Line buffer contents are not reset. Stale data never reaches the output, because the eligibility rule guarantees every emitted byte was written in the current frame.
- No arithmetic; pure data movement. Counter widths are $clog2 of each dimension.

## Timing
- Reset (`i_rstn` low, asynchronous assert) sets the following, immediately and held while low:
  - `row` = 0 and `col` = 0.
  - Window register = 0, so `o_pixel_data` = 72'h0.
  - `o_pixel_data_valid` = 0 and `o_frame_done` = 0.
- Latency: the pixel accepted at edge N produces its window on `o_pixel_data`, with `o_pixel_data_valid` = 1 during the cycle after edge N.
- `o_pixel_data` updates on every accepted pixel, eligible or not. It holds its value on idle cycles. It is meaningful only while valid.
- `o_pixel_data_valid` is high for exactly one cycle per eligible pixel. With back-to-back input it can stay high continuously. It is low on idle cycles.
- `o_frame_done` is high during the cycle after the edge accepting (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the frame's last `o_pixel_data_valid`.
- Back-to-back frames need no gap cycles. The first pixel after the wrap is (0, 0) of the next frame.
- Reset mid-frame aborts the frame: no `o_frame_done`, and the next accepted pixel is (0, 0). No valid output appears until (2, 2) of the new frame.
- Idle gaps of any length, at any position including mid-row, do not change output values or ordering.

## Test plan
Bench parameters are IMG_WIDTH = 4 and IMG_HEIGHT = 4. Pixel value = 16·row + col.
- **Reset values:** hold `i_rstn` low with random inputs → `o_pixel_data` = 0, `o_pixel_data_valid` = 0, `o_frame_done` = 0, with no clock required for the assert to take effect.
- **First window:** stream pixels 0x00..0x22 back-to-back → the first valid appears one cycle after 0x22 is accepted, with `o_pixel_data` = 72'h22_21_20_12_11_10_02_01_00. There is no earlier valid.
- **Full frame:** stream all 16 pixels → exactly 4 valid windows, in order centred at 0x11, 0x12, 0x21, 0x22.
  - The last window is 72'h33_32_31_23_22_21_13_12_11.
  - `o_frame_done` pulses together with that last valid.
- **Gaps:** repeat the full frame with 0–3 random idle cycles between pixels → the same 4 windows in the same order. Valid asserts only in cycles following accepted pixels, and `o_pixel_data` holds across gaps.
- **Two consecutive frames:** second frame pixel value = 0x80 + 16·row + col → its first window is 72'hA2_A1_A0_92_91_90_82_81_80, containing no first-frame bytes. There are two `o_frame_done` pulses in total.
- **Reset mid-frame:** pulse `i_rstn` low after pixel 0x21, then stream a fresh frame → no valid output before the new pixel 0x22. There is no `o_frame_done` for the aborted frame, and the new frame's output matches the full-frame case.
